// File: rtl/pcg_arbiter.sv
// Shares one 16-bit LCG, with an 8-bit permuted output, between N_REQ round-robin requesters.
// Each grant returns one byte and advances the generator once. Warm-up follows reset or reseed.
module pcg_arbiter #(
  parameter int          N_REQ      = 4,
  parameter logic [15:0] RESET_SEED = 16'd4356,
  parameter int          WARMUP     = 4,
  parameter logic [15:0] MULT       = 16'd12829,
  parameter logic [15:0] INC        = 16'd47989
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [7:0]       rnd,
  output logic             busy
);

  localparam int         PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

  typedef enum logic {ST_WARMUP, ST_SERVE} fsm_t;
  localparam fsm_t START_ST = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  fsm_t             fsm_q, fsm_d;
  logic [15:0]      state_q, state_d;
  logic [7:0]       rnd_d;
  logic [N_REQ-1:0] gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             found;
  logic [PW-1:0]    win;

  function automatic logic [15:0] lcg_step(input logic [15:0] s);
    return s * MULT + INC;
  endfunction

  function automatic logic [7:0] lcg_perm(input logic [15:0] s);
    logic [3:0]  sh;
    logic [15:0] p;
    sh = {1'b0, s[15:13]} + 4'd3;
    p  = ((s >> sh) ^ s) * 16'd62169;
    return p[15:8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= START_ST;
      state_q <= RESET_SEED;
      rnd     <= 8'd0;
      gnt     <= '0;
      ptr_q   <= '0;
      wcnt_q  <= WARMUP_CNT;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd     <= rnd_d;
      gnt     <= gnt_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // A reseed wins over any grant this edge, so a pending request stays pending.
  always_comb begin
    int unsigned idx;
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd;
    gnt_d   = '0;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    found   = 1'b0;
    win     = '0;
    idx     = 0;

    for (int i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + 32'(i);
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end

    if (seed_load) begin
      state_d = seed;
      wcnt_d  = WARMUP_CNT;
      fsm_d   = START_ST;
    end else begin
      case (fsm_q)
        ST_WARMUP: begin
          state_d = lcg_step(state_q);
          wcnt_d  = wcnt_q - 8'd1;
          if (wcnt_q <= 8'd1) fsm_d = ST_SERVE;
        end
        ST_SERVE: begin
          if (found) begin
            gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            rnd_d   = lcg_perm(state_q);
            state_d = lcg_step(state_q);
            if (32'(win) == 32'(N_REQ - 1)) ptr_d = '0;
            else                            ptr_d = win + PW'(1);
          end
        end
        default: fsm_d = START_ST;
      endcase
    end
  end

  assign busy = (fsm_q == ST_WARMUP);

endmodule

// File: doc/pcg_arbiter.md
Name: pcg_arbiter

Overview:
Owns the 16-bit LCG state and its 8-bit permuted output, and shares that generator between N_REQ demo-effect consumers. Arbitration is round-robin. Each grant delivers exactly one fresh byte and advances the generator exactly once, so the sequence is deterministic for a given grant order. It also handles reseeding, and runs a warm-up phase after reset or reseed during which no grants are issued.

Parameters:
N_REQ, 4, number of requesters (2..8)
RESET_SEED, 16'd4356, LCG state loaded at reset
WARMUP, 4, generator steps discarded after reset or seed load (0..255); 0 means none
MULT, 16'd12829, LCG multiplier
INC, 16'd47989, LCG increment

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
seed_load  input  1  one-cycle pulse: load seed into the LCG state
seed  input  16  seed value, sampled when seed_load=1
req  input  N_REQ  per-requester level request
gnt  output  N_REQ  registered one-hot grant; rnd is valid in the same cycle
rnd  output  8  registered random byte
busy  output  1  high while in WARMUP

Behaviour:
- Clocking and reset: one clock is `clk`; reset is `rst_n`, asynchronous and active-low.
- On reset:
  - state=RESET_SEED, rnd=0, gnt=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - Warm-up counter wcnt=WARMUP.
  - FSM enters WARMUP, or SERVE if WARMUP=0.
  - busy=1 iff FSM=WARMUP.
- Step function: step(s) = (s*MULT + INC) mod 2^16.
- Permute function:
  - sh = s[15:13] + 3, range 3..10.
  - p = (((s >> sh) ^ s) * 16'd62169) mod 2^16.
  - perm(s) = p[15:8].
- FSM WARMUP:
  - Each cycle: state<=step(state), wcnt<=wcnt-1, gnt=0, rnd holds.
  - When wcnt reaches 1 on an advance, go to SERVE on the next edge.
  - Exactly WARMUP steps are taken.
- FSM SERVE:
  - Each edge, search req starting at ptr, wrapping modulo N_REQ; the first set bit k wins.
  - If a winner exists: gnt<=onehot(k), rnd<=perm(state), state<=step(state), ptr<=(k+1) mod N_REQ.
  - If no winner: gnt<=0, state, rnd and ptr hold.
- Latency: req high at edge t produces gnt/rnd valid after edge t (1 cycle).
- Handshake:
  - req is level and sampled every edge.
  - A requester that wants one byte must deassert req in the cycle its gnt is high.
  - A requester that keeps req high, with no competitors, receives a new byte every cycle.
- Fairness: with all req held high, grants rotate 0,1,..,N_REQ-1,0,... with no starvation.
- seed_load, in any state:
  - Next edge: state<=seed, wcnt<=WARMUP, gnt<=0, FSM goes to WARMUP (or SERVE if WARMUP=0). ptr holds.
  - seed_load has priority over a simultaneous grant; that request is not consumed and stays pending.
- seed_load during WARMUP restarts warm-up from the new seed.
- rnd is not cleared by seed_load; it only changes on a grant.
- rst_n asserted mid-operation: all registers return to reset values immediately, asynchronously; any grant in flight is lost.
- Arithmetic: all products and sums are truncated to 16 bits. No signed arithmetic is used.

Test Plan:
1. Sequence check. WARMUP=0, reset, req[0] held high for 2 cycles: rnd=0x41 then 0xA0; internal state goes 0x1104 -> 0x70E9 -> next.
2. Round-robin. WARMUP=0, req=4'b1111 held for 8 cycles: gnt = 0001,0010,0100,1000,0001,...; each rnd matches the reference-model sequence from 0x1104.
3. Warm-up. WARMUP=4, reset, req[2] high from the first cycle: busy=1 for exactly 4 cycles, no gnt. The first gnt[2] carries perm(step^4(0x1104)).
4. Reseed collision. In SERVE with req[1] high, pulse seed_load with seed=0x1104 (WARMUP=0) on the same edge: gnt=0 that cycle. The next cycle gnt[1]=1 with rnd=0x41.
5. Idle hold. No req for 10 cycles: gnt=0, rnd unchanged, and the next grant yields the byte that would have come next without the gap.
6. Async reset mid-grant. Drop rst_n between edges while gnt is high: gnt=0, rnd=0, busy per WARMUP immediately without a clock edge. After release the sequence restarts at 0x41 (WARMUP=0).
